ram_scan_reader: RTL and testbench

- Autonomous read-side master for the lab dual-port RAM read port; it complements the switch-driven write path.
- Walks an address window [first_addr..last_addr]. For each address it issues a read, captures the word, and presents address and data for the 7-segment display stage for a programmable dwell time.
- Dwell ends on a prescaler tick (auto mode) or on a manual step pulse (step mode).
- Sits between the RAM read port and the hex-to-7-segment decoders.

---
 rtl/ram_scan_reader_pkg.sv | 11 +
 rtl/ram_scan_reader_dwell_timer.sv | 42 ++++
 rtl/ram_scan_reader.sv | 146 ++++++++++++++
 tb/tb_ram_scan_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_reader_pkg.sv
// Shared definitions for the RAM scan reader: FSM state encoding.
package ram_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

endpackage

// File: rtl/ram_scan_reader_dwell_timer.sv
// Dwell prescaler: counts enabled cycles and flags the last one of each
// TICK_DIV-cycle dwell with a one-cycle expire pulse.
module dwell_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == CNT_LAST);

    // Next count: clear wins, hold when disabled or on the expiring cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side scan master: walks an address window of the RAM read port and
// holds each captured word on the display outputs for one dwell period.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop,
    input  logic                  manual,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] disp_addr,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_valid,
    output logic                  busy,
    output logic                  done
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;
    logic [ADDR_WIDTH-1:0]   last_q, last_d;
    logic [ADDR_WIDTH-1:0]   disp_addr_q, disp_addr_d;
    logic [DATA_WIDTH-1:0]   disp_data_q, disp_data_d;
    logic                    disp_valid_q, disp_valid_d;
    logic                    done_q, done_d;
    logic                    tmr_clr_s, tmr_en_s, tmr_expire_s;
    logic                    advance_s;

    // The counter only runs while dwelling in auto mode; in manual mode it holds.
    assign tmr_clr_s = (state_q == S_CAPTURE);
    assign tmr_en_s  = (state_q == S_HOLD) && !manual;
    assign advance_s = manual ? step : tmr_expire_s;

    dwell_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr_s),
        .en_i     (tmr_en_s),
        .expire_o (tmr_expire_s)
    );

    // Next-state logic for the FSM, address walker and capture registers.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        first_d      = first_q;
        last_d       = last_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    first_d   = first_addr;
                    last_d    = last_addr;
                    rd_addr_d = first_addr;
                    state_d   = S_ISSUE;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    disp_data_d  = rd_data;
                    disp_addr_d  = rd_addr_q;
                    disp_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (advance_s) begin
                    if (rd_addr_q != last_q) begin
                        rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                        state_d   = S_ISSUE;
                    end else if (loop) begin
                        rd_addr_d = first_q;
                        state_d   = S_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            first_q      <= '0;
            last_q       <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            first_q      <= first_d;
            last_q       <= last_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            done_q       <= done_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed self-checking bench for ram_scan_reader with TICK_DIV=4 and a
// 1-cycle-latency RAM model holding mem[a] = 8'hA0 + a.
module tb_ram_scan_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          loop;
    logic          manual;
    logic          step;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          busy;
    logic          done;

    int n_checks;
    int n_errors;
    int done_seen;

    ram_scan_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TICK_DIV   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .loop       (loop),
        .manual     (manual),
        .step       (step),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port model: registered output, one cycle latency.
    always @(posedge clk) begin
        rd_data <= 8'hA0 + {4'h0, rd_addr};
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance n edges; sample #1 after each edge and count done pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic check_disp(input string tag, input int a);
        check_val({tag, "_addr"}, int'(disp_addr), a);
        check_val({tag, "_data"}, int'(disp_data), 8'hA0 + a);
        check_val({tag, "_valid"}, int'(disp_valid), 1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; done_seen = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
        manual = 1'b0; step = 1'b0; first_addr = 4'd0; last_addr = 4'd0;
        tick(2);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_valid", int'(disp_valid), 0);
        check_val("rst_rdaddr", int'(rd_addr), 0);
        check_val("rst_done", int'(done), 0);
        rst = 1'b0;
        tick(1);

        // Auto single pass 2..4
        pulse_start(4'd2, 4'd4);
        check_val("a_busy", int'(busy), 1);
        check_val("a_rdaddr", int'(rd_addr), 2);
        tick(1);
        check_val("a_valid_e1", int'(disp_valid), 0);
        tick(1);
        check_disp("a2", 2);
        tick(5);
        check_val("a2_hold", int'(disp_addr), 2);
        tick(1);
        check_disp("a3", 3);
        tick(6);
        check_disp("a4", 4);
        done_seen = 0;
        tick(3);
        check_val("a_done_early", int'(done), 0);
        check_val("a_busy_pre", int'(busy), 1);
        tick(1);
        check_val("a_done", int'(done), 1);
        check_val("a_busy_fall", int'(busy), 0);
        tick(1);
        check_val("a_done_pulse", int'(done), 0);
        check_val("a_done_count", done_seen, 1);

        // Wrap window 14..1
        pulse_start(4'd14, 4'd1);
        tick(2);
        check_disp("w14", 14);
        tick(6);
        check_disp("w15", 15);
        tick(6);
        check_disp("w0", 0);
        tick(6);
        check_disp("w1", 1);
        tick(4);
        check_val("w_done", int'(done), 1);
        check_val("w_busy", int'(busy), 0);

        // Loop mode 5..6, abort at second visit of 6
        loop = 1'b1;
        done_seen = 0;
        pulse_start(4'd5, 4'd6);
        tick(2);
        check_disp("l5a", 5);
        tick(6);
        check_disp("l6a", 6);
        tick(6);
        check_disp("l5b", 5);
        tick(6);
        check_disp("l6b", 6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_val("l_abort_busy", int'(busy), 0);
        check_disp("l_retain", 6);
        check_val("l_no_done", done_seen, 0);
        loop = 1'b0;

        // abort together with start in IDLE: no scan
        abort = 1'b1;
        pulse_start(4'd1, 4'd2);
        abort = 1'b0;
        check_val("as_busy", int'(busy), 0);

        // Manual mode, single-address window 9
        manual = 1'b1;
        pulse_start(4'd9, 4'd9);
        tick(2);
        check_disp("m9", 9);
        tick(100);
        check_disp("m9_hold", 9);
        check_val("m_busy", int'(busy), 1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check_val("m_done", int'(done), 1);
        check_val("m_idle", int'(busy), 0);
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(1);
        end
        check_val("m_step_idle_busy", int'(busy), 0);
        check_val("m_step_idle_done", done_seen, 0);
        check_val("m_step_idle_addr", int'(disp_addr), 9);
        manual = 1'b0;

        // Reset while in CAPTURE
        pulse_start(4'd3, 4'd7);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_val("r_busy", int'(busy), 0);
        check_val("r_rdaddr", int'(rd_addr), 0);
        check_val("r_daddr", int'(disp_addr), 0);
        check_val("r_ddata", int'(disp_data), 0);
        check_val("r_valid", int'(disp_valid), 0);
        check_val("r_done", int'(done), 0);

        // start while busy is ignored and window is not re-latched
        pulse_start(4'd3, 4'd5);
        tick(2);
        check_disp("s3", 3);
        pulse_start(4'd10, 4'd12);
        tick(5);
        check_disp("s4", 4);
        tick(6);
        check_disp("s5", 5);
        tick(4);
        check_val("s_done", int'(done), 1);
        check_val("s_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
